// File: rtl/mem_resp_pkg.sv
// Shared types for the memory-stage response queue: size encodings,
// per-entry control record and the bus-width legality check.
package mem_resp_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef logic [1:0] size_t;

  // Offset, meta and data live in their own arrays because their widths follow
  // the module parameters.
  typedef struct packed {
    logic  is_load;
    size_t size;
    logic  sgn;
  } entry_ctrl_t;

  function automatic bit data_w_legal(int unsigned w);
    return (w == 32) || (w == 64);
  endfunction

endpackage

// File: rtl/mem_resp_queue_if.sv
// EXE/WB-facing handshake bundle of the response queue; the queue takes the
// slave modport, the pipeline side takes master.
interface mem_resp_queue_if #(
  parameter int DATA_W = 32,
  parameter int META_W = 8,
  parameter int DEPTH  = 4
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              req_issue;
  logic              req_is_load;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [OFF_W-1:0]  req_offset;
  logic [META_W-1:0] req_meta;
  logic              req_full;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_is_load;
  logic [DATA_W-1:0] out_data;
  logic [META_W-1:0] out_meta;
  logic [CNT_W-1:0]  pending_cnt;

  modport master (
    output req_issue, req_is_load, req_size, req_signed, req_offset, req_meta,
    output data_ok, rdata, flush, out_ready,
    input  req_full, out_valid, out_is_load, out_data, out_meta, pending_cnt
  );

  modport slave (
    input  req_issue, req_is_load, req_size, req_signed, req_offset, req_meta,
    input  data_ok, rdata, flush, out_ready,
    output req_full, out_valid, out_is_load, out_data, out_meta, pending_cnt
  );
endinterface

// File: rtl/load_extend.sv
// Load data aligner: picks the addressed byte/half/word out of the bus word
// and sign- or zero-extends it to the full bus width.
module load_extend
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  size_t             size_i,
  input  logic              sgn_i,
  input  logic [OFF_W-1:0]  offset_i,
  output logic [DATA_W-1:0] res_o
);

  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;
  logic              sb;

  always_comb begin
    sh   = rdata_i >> {offset_i, 3'b000};
    mask = '1;
    sb   = 1'b0;
    case (size_i)
      SZ_B: begin mask = DATA_W'(8'hFF);         sb = sh[7];  end
      SZ_H: begin mask = DATA_W'(16'hFFFF);      sb = sh[15]; end
      SZ_W: begin mask = DATA_W'(32'hFFFF_FFFF); sb = sh[31]; end
      default: ;
    endcase
    // Bits above the field are either all sign copies or all zero.
    res_o = (sh & mask) | ((sgn_i && sb) ? ~mask : '0);
  end

endmodule

// File: rtl/mem_resp_queue.sv
// Tracks up to DEPTH outstanding data-bus requests, pairs in-order responses
// with their metadata and hands finished entries to WB. MEM_RESP_BYPASS_EN
// lets a response to the head entry reach WB in the same cycle.
module mem_resp_queue
  import mem_resp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int META_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  mem_resp_queue_if.slave  bus
);

  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!data_w_legal(DATA_W) || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("mem_resp_queue: DATA_W must be 32/64 and DEPTH a power of two >= 2");
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  logic [CNT_W-1:0] head_q, head_d, resp_q, resp_d, tail_q, tail_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [DEPTH-1:0] done_q;

  entry_ctrl_t [DEPTH-1:0]             ctrl_q;
  logic        [DEPTH-1:0][OFF_W-1:0]  off_q;
  logic        [DEPTH-1:0][META_W-1:0] meta_q;
  logic        [DEPTH-1:0][DATA_W-1:0] data_q;

  logic [CNT_W-1:0]  live, outst, occ;
  logic [PTR_W-1:0]  hslot, rslot, tslot;
  logic              push, pop, dok_drop, dok_acc, byp, head_vld;
  logic [DATA_W-1:0] ext_src, ext_res;

  assign live  = tail_q - head_q;
  assign outst = tail_q - resp_q;
  assign occ   = live + drop_q;
  assign hslot = head_q[PTR_W-1:0];
  assign rslot = resp_q[PTR_W-1:0];
  assign tslot = tail_q[PTR_W-1:0];

  // Full depends on registered state only, so out_ready never reaches it.
  assign bus.req_full    = (occ == CNT_W'(DEPTH));
  assign bus.pending_cnt = occ;

  assign push     = bus.req_issue && !bus.req_full;
  assign dok_drop = bus.data_ok && (drop_q != '0);
  assign dok_acc  = bus.data_ok && (drop_q == '0) && (outst != '0);

`ifdef MEM_RESP_BYPASS_EN
  assign byp     = dok_acc && (resp_q == head_q);
  assign ext_src = byp ? bus.rdata : data_q[hslot];
`else
  assign byp     = 1'b0;
  assign ext_src = data_q[hslot];
`endif

  assign head_vld = done_q[hslot] | byp;
  assign pop      = head_vld && bus.out_ready;

  always_comb begin
    head_d = head_q + CNT_W'(pop);
    resp_d = resp_q + CNT_W'(dok_acc);
    tail_d = tail_q + CNT_W'(push);
    drop_d = drop_q - CNT_W'(dok_drop);
    if (bus.flush) begin
      head_d = '0;
      resp_d = '0;
      tail_d = '0;
      // Everything still owed by the bus after this edge must be swallowed.
      drop_d = drop_q + outst + CNT_W'(push) - CNT_W'(dok_drop | dok_acc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      resp_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      resp_q <= resp_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
      if (bus.flush) begin
        done_q <= '0;
      end else begin
        if (dok_acc && !(byp && pop)) done_q[rslot] <= 1'b1;
        if (pop)                      done_q[hslot] <= 1'b0;
      end
    end
  end

  // Payload storage needs no reset: it is only observed behind done bits.
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_q[tslot] <= '{is_load: bus.req_is_load, size: bus.req_size, sgn: bus.req_signed};
      off_q[tslot]  <= bus.req_offset;
      meta_q[tslot] <= bus.req_meta;
    end
    if (dok_acc) data_q[rslot] <= bus.rdata;
  end

  load_extend #(.DATA_W(DATA_W)) u_ext (
    .rdata_i  (ext_src),
    .size_i   (ctrl_q[hslot].size),
    .sgn_i    (ctrl_q[hslot].sgn),
    .offset_i (off_q[hslot]),
    .res_o    (ext_res)
  );

  assign bus.out_valid   = head_vld;
  assign bus.out_is_load = head_vld && ctrl_q[hslot].is_load;
  assign bus.out_data    = bus.out_is_load ? ext_res : '0;
  assign bus.out_meta    = head_vld ? meta_q[hslot] : '0;

endmodule
